fmul_seq: RTL and testbench



---
 rtl/fmul_seq.sv | 157 +++++++++++++++
 tb/tb_fmul_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fmul_seq.sv
// rtl/fmul_seq.sv - sequential binary32 multiplier, shift-add mantissa datapath, FTZ
module fmul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_num
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_NORM  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_sign;
  logic               r_rtz;
  logic [23:0]        r_ma;
  logic [23:0]        r_mb;
  logic [47:0]        r_p;
  logic [4:0]         r_cnt;
  logic signed [9:0]  r_e;
  logic [23:0]        r_m;
  logic               r_g;
  logic               r_s;
  logic [31:0]        r_out;

  // Operand classification, evaluated on the raw inputs at accept
  logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic w_nan_case, w_inf_case, w_zero_case, w_special;
  logic w_sign, w_accept;
  logic [31:0] w_special_val;
  logic signed [9:0] w_e_init;

  assign w_a_zero    = (num1[30:23] == 8'h00);
  assign w_b_zero    = (num2[30:23] == 8'h00);
  assign w_a_inf     = (num1[30:23] == 8'hFF) && (num1[22:0] == 23'd0);
  assign w_b_inf     = (num2[30:23] == 8'hFF) && (num2[22:0] == 23'd0);
  assign w_a_nan     = (num1[30:23] == 8'hFF) && (num1[22:0] != 23'd0);
  assign w_b_nan     = (num2[30:23] == 8'hFF) && (num2[22:0] != 23'd0);
  assign w_nan_case  = w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero);
  assign w_inf_case  = w_a_inf || w_b_inf;
  assign w_zero_case = w_a_zero || w_b_zero;
  assign w_special   = w_nan_case || w_inf_case || w_zero_case;
  assign w_sign      = num1[31] ^ num2[31];
  assign w_accept    = in_valid && (r_state == S_IDLE);
  assign w_e_init    = $signed({2'b00, num1[30:23]} + {2'b00, num2[30:23]} - 10'd127);

  always_comb begin
    w_special_val = {w_sign, 31'd0};
    if (w_nan_case)      w_special_val = 32'h7FC0_0000;
    else if (w_inf_case) w_special_val = {w_sign, 8'hFF, 23'd0};
  end

  // Rounding and final packing, consumed on the edge leaving ROUND
  logic              w_inc;
  logic [24:0]       w_msum;
  logic [23:0]       w_m_fin;
  logic signed [9:0] w_e_fin;
  logic [31:0]       w_result;
  logic [47:0]       w_addend;

  assign w_addend = r_mb[0] ? ({24'd0, r_ma} << r_cnt) : 48'd0;
  assign w_inc    = !r_rtz && r_g && (r_s || r_m[0]);
  assign w_msum   = {1'b0, r_m} + {24'd0, w_inc};
  assign w_m_fin  = w_msum[24] ? 24'h80_0000 : w_msum[23:0];
  assign w_e_fin  = w_msum[24] ? (r_e + 10'sd1) : r_e;

  always_comb begin
    w_result = {r_sign, w_e_fin[7:0], w_m_fin[22:0]};
    if (w_e_fin >= 10'sd255)    w_result = {r_sign, 8'hFF, 23'd0};
    else if (w_e_fin <= 10'sd0) w_result = {r_sign, 31'd0};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = w_special ? S_DONE : S_MUL;
      S_MUL:   if (r_cnt == 5'd23) w_next = S_NORM;
      S_NORM:  w_next = S_ROUND;
      S_ROUND: w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    out_num   = r_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign <= 1'b0;
      r_rtz  <= 1'b0;
      r_ma   <= 24'd0;
      r_mb   <= 24'd0;
      r_p    <= 48'd0;
      r_cnt  <= 5'd0;
      r_e    <= 10'sd0;
      r_m    <= 24'd0;
      r_g    <= 1'b0;
      r_s    <= 1'b0;
      r_out  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sign <= w_sign;
            r_rtz  <= (rm == 3'b001);
            r_ma   <= {1'b1, num1[22:0]};
            r_mb   <= {1'b1, num2[22:0]};
            r_p    <= 48'd0;
            r_cnt  <= 5'd0;
            r_e    <= w_e_init;
            if (w_special) r_out <= w_special_val;
          end
        end
        S_MUL: begin
          r_p   <= r_p + w_addend;
          r_mb  <= r_mb >> 1;
          r_cnt <= r_cnt + 5'd1;
        end
        S_NORM: begin
          if (r_p[47]) begin
            r_m <= r_p[47:24];
            r_g <= r_p[23];
            r_s <= |r_p[22:0];
            r_e <= r_e + 10'sd1;
          end else begin
            r_m <= r_p[46:23];
            r_g <= r_p[22];
            r_s <= |r_p[21:0];
          end
        end
        S_ROUND: r_out <= w_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fmul_seq.sv
// tb/tb_fmul_seq.sv - directed vector table plus backpressure and mid-op reset sequences
module tb_fmul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] num1;
  logic [31:0] num2;
  logic [2:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_num;

  int errors = 0;
  int checks = 0;

  fmul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num1      (num1),
    .num2      (num2),
    .rm        (rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_num   (out_num)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  m;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    num1 = a; num2 = b; rm = m; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    num1 = $urandom; num2 = $urandom; rm = 3'($urandom_range(0, 7));
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    res = out_num;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] res;
    int          lat;
    int          seen;
    vecs[0]  = '{32'h3FC00000, 32'h40000000, 3'b000, 32'h40400000, 27};
    vecs[1]  = '{32'hC0400000, 32'h3F000000, 3'b000, 32'hBFC00000, 27};
    vecs[2]  = '{32'h3FC00001, 32'h3F800001, 3'b000, 32'h3FC00003, 27};
    vecs[3]  = '{32'h3FC00001, 32'h3F800001, 3'b001, 32'h3FC00002, 27};
    vecs[4]  = '{32'h3FC00001, 32'h3F800001, 3'b101, 32'h3FC00003, 27};
    vecs[5]  = '{32'h7F000000, 32'h40000000, 3'b000, 32'h7F800000, 27};
    vecs[6]  = '{32'h00800000, 32'h3F000000, 3'b000, 32'h00000000, 27};
    vecs[7]  = '{32'h00000001, 32'h3F800000, 3'b000, 32'h00000000, 1};
    vecs[8]  = '{32'h7F800000, 32'h00000000, 3'b000, 32'h7FC00000, 1};
    vecs[9]  = '{32'hFF800000, 32'h40000000, 3'b000, 32'hFF800000, 1};
    vecs[10] = '{32'h7FC00001, 32'h3F800000, 3'b000, 32'h7FC00000, 1};
    vecs[11] = '{32'h3F800001, 32'h3FFFFFFE, 3'b000, 32'h40000000, 27};
    vecs[12] = '{32'h3F800001, 32'h3FFFFFFE, 3'b001, 32'h3FFFFFFF, 27};
    vecs[13] = '{32'h7F000000, 32'h3F800000, 3'b000, 32'h7F000000, 27};
    vecs[14] = '{32'h00800000, 32'h3F800000, 3'b000, 32'h00800000, 27};
    vecs[15] = '{32'h80000000, 32'h40A00000, 3'b000, 32'h80000000, 1};
    vecs[16] = '{32'h7F800000, 32'hFF800000, 3'b000, 32'hFF800000, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; num1 = '0; num2 = '0; rm = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_num", out_num, 32'd0);

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].m, res, lat);
      chk($sformatf("vec%0d result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      @(negedge clk);
      chk($sformatf("vec%0d handoff in_ready", i), {31'd0, in_ready}, 32'd1);
      chk($sformatf("vec%0d handoff out_valid", i), {31'd0, out_valid}, 32'd0);
    end

    // Backpressure: result held, new operands refused
    @(negedge clk);
    num1 = 32'h3FC00000; num2 = 32'h40000000; rm = 3'b000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 100 && !out_valid) begin
      @(negedge clk);
      lat++;
    end
    chk("bp latency", lat, 27);
    for (int k = 0; k < 5; k++) begin
      num1 = 32'h7F800000; num2 = 32'h00000000; in_valid = 1'b1;
      chk($sformatf("bp hold%0d out_num", k), out_num, 32'h40400000);
      chk($sformatf("bp hold%0d in_ready", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp hold%0d out_valid", k), {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp final out_num", out_num, 32'h40400000);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp release out_valid", {31'd0, out_valid}, 32'd0);

    // Reset at t0+10 discards the in-flight product
    @(negedge clk);
    num1 = 32'h3FC00000; num2 = 32'h40000000; rm = 3'b000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst no stale result", seen, 0);
    run_op(32'h3FC00001, 32'h3F800001, 3'b000, res, lat);
    chk("midrst new result", res, 32'h3FC00003);
    chk("midrst new latency", lat, 27);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
